// File: rtl/clock_pkg.sv
// Shared definitions for the BCD time-of-day keeper: digit width, digit limits
// and the RUN/SET mode encoding.
package clock_pkg;

    localparam int BCD_W          = 4;
    localparam int MAX_H1         = 2;
    localparam int MAX_H0_AT_H1_2 = 3;
    localparam int MAX_M1         = 5;
    localparam int MAX_S1         = 5;
    localparam int BCD_MAX        = 9;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter. ONES_MAX_AT_TOP lets the ones digit wrap early
// once the tens digit sits at its limit (hours wrap at 23).
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int TENS_MAX        = MAX_S1,
    parameter int ONES_MAX        = BCD_MAX,
    parameter int ONES_MAX_AT_TOP = ONES_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry_out
);

    bcd_t ones_lim;
    logic at_top;
    logic ones_wrap;

    always_comb begin
        at_top    = (tens == bcd_t'(TENS_MAX));
        ones_lim  = at_top ? bcd_t'(ONES_MAX_AT_TOP) : bcd_t'(ONES_MAX);
        ones_wrap = (ones >= ones_lim);
        carry_out = inc && !clear && ones_wrap && at_top;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones_wrap) begin
                ones <= '0;
                tens <= at_top ? '0 : tens + bcd_t'(1);
            end else begin
                ones <= ones + bcd_t'(1);
            end
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour BCD clock: free-running one-second prescaler, RUN/SET mode machine and
// synchronized hour/minute advance buttons.
//   state  | meaning
//   ST_RUN | time advances on each tick; buttons ignored
//   ST_SET | time held, seconds cleared on entry; button pulses advance h/m
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_time,
    input  logic             btn_h,
    input  logic             btn_m,
    output logic [BCD_W-1:0] H_1,
    output logic [BCD_W-1:0] H_0,
    output logic [BCD_W-1:0] M_1,
    output logic [BCD_W-1:0] M_0,
    output logic [BCD_W-1:0] sec_led,
    output logic             tick
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PS_PRE  = PW'(TICK_DIV - 2);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    logic [PW-1:0] prescale;
    logic          set_meta, set_sync;
    logic          h_meta, h_sync, h_prev;
    logic          m_meta, m_sync, m_prev;
    logic          h_pulse, m_pulse;
    state_t        state, state_next;
    logic          sec_clr, sec_inc, in_set;
    logic          min_inc, hr_inc;
    logic          sec_carry, min_carry, hr_carry;
    bcd_t          sec_tens;
    logic          unused_bits;

    // tick is registered one count early so it is high exactly while prescale == TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            tick     <= 1'b0;
        end else begin
            prescale <= (prescale == PS_LAST) ? '0 : prescale + PS_ONE;
            tick     <= (prescale == PS_PRE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_meta <= 1'b0;
            set_sync <= 1'b0;
            h_meta   <= 1'b0;
            h_sync   <= 1'b0;
            h_prev   <= 1'b0;
            m_meta   <= 1'b0;
            m_sync   <= 1'b0;
            m_prev   <= 1'b0;
        end else begin
            set_meta <= set_time;
            set_sync <= set_meta;
            h_meta   <= btn_h;
            h_sync   <= h_meta;
            h_prev   <= h_sync;
            m_meta   <= btn_m;
            m_sync   <= m_meta;
            m_prev   <= m_sync;
        end
    end

    assign h_pulse = h_sync & ~h_prev;
    assign m_pulse = m_sync & ~m_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // The clk that enters SET clears seconds instead of advancing them
    always_comb begin
        state_next = state;
        sec_clr    = 1'b0;
        sec_inc    = 1'b0;
        case (state)
            ST_RUN: begin
                if (set_sync) begin
                    state_next = ST_SET;
                    sec_clr    = 1'b1;
                end else begin
                    sec_inc = tick;
                end
            end
            ST_SET: begin
                if (!set_sync) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign in_set  = (state == ST_SET);
    assign min_inc = sec_carry | (in_set & m_pulse);
    assign hr_inc  = (~in_set & min_carry) | (in_set & h_pulse);

    bcd_mod_counter #(
        .TENS_MAX(MAX_S1),
        .ONES_MAX(BCD_MAX)
    ) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_inc),
        .clear    (sec_clr),
        .tens     (sec_tens),
        .ones     (sec_led),
        .carry_out(sec_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX(MAX_M1),
        .ONES_MAX(BCD_MAX)
    ) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_inc),
        .clear    (1'b0),
        .tens     (M_1),
        .ones     (M_0),
        .carry_out(min_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX       (MAX_H1),
        .ONES_MAX       (BCD_MAX),
        .ONES_MAX_AT_TOP(MAX_H0_AT_H1_2)
    ) u_hr (
        .clk      (clk),
        .rst      (rst),
        .inc      (hr_inc),
        .clear    (1'b0),
        .tens     (H_1),
        .ones     (H_0),
        .carry_out(hr_carry)
    );

    // seconds tens is internal only and the hour wrap has nowhere to carry
    assign unused_bits = ^{sec_tens, hr_carry};

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper: a seconds/minutes/hours model predicts
// every visible digit change; a monitor pops and compares on each change.
module tb_clock_timekeeper;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_time = 1'b0;
    logic       btn_h = 1'b0;
    logic       btn_m = 1'b0;
    logic [3:0] H_1, H_0, M_1, M_0, sec_led;
    logic       tick;

    clock_timekeeper #(.TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .set_time(set_time),
        .btn_h   (btn_h),
        .btn_m   (btn_m),
        .H_1     (H_1),
        .H_0     (H_0),
        .M_1     (M_1),
        .M_0     (M_0),
        .sec_led (sec_led),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          hh = 0, mm = 0, ss = 0;
    logic [19:0] exp_q[$];
    logic [19:0] prev_disp = '0;
    logic [19:0] cur_disp;
    int          since_tick = 0;

    function automatic logic [19:0] pack_time(int h, int m, int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] disp_now();
        return {H_1, H_0, M_1, M_0, sec_led};
    endfunction

    task automatic check(string name, logic [19:0] act, logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every change of the visible digits consumes one predicted value
    always @(negedge clk) begin
        cur_disp = disp_now();
        if (rst) begin
            since_tick = 0;
        end else begin
            if (cur_disp !== prev_disp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %h, required %h (nothing queued)",
                             cur_disp, prev_disp);
                end else begin
                    check("scoreboard", cur_disp, exp_q.pop_front());
                end
            end
            since_tick++;
            if (tick) begin
                check("tick_spacing", 20'(since_tick), 20'(TICK_DIV));
                since_tick = 0;
            end
        end
        prev_disp = cur_disp;
    end

    task automatic advance_second();
        ss++;
        if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                hh = (hh + 1) % 24;
            end
        end
    endtask

    task automatic wait_ticks(int n, bit toggle);
        int seen = 0;
        int budget = n * TICK_DIV + 8;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (tick) seen++;
            if (toggle && (n - seen) > 1) begin
                btn_m = 1'($urandom_range(0, 1));
                btn_h = 1'($urandom_range(0, 1));
            end else begin
                btn_m = 1'b0;
                btn_h = 1'b0;
            end
        end
        if (seen < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: saw %0d ticks, required %0d", seen, n);
        end
    endtask

    // Returns just after the edge that applied the last increment
    task automatic run_ticks(int n, bit toggle);
        for (int i = 0; i < n; i++) begin
            advance_second();
            exp_q.push_back(pack_time(hh, mm, ss));
        end
        wait_ticks(n, toggle);
        @(posedge clk);
        #1;
    endtask

    task automatic enter_set();
        set_time = 1'b1;
        if (ss % 10 != 0) exp_q.push_back(pack_time(hh, mm, 0));
        ss = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic leave_set();
        wait_ticks(1, 1'b0);
        @(posedge clk);
        #1;
        set_time = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic press(bit h, bit m);
        if (h) hh = (hh + 1) % 24;
        if (m) mm = (mm + 1) % 60;
        exp_q.push_back(pack_time(hh, mm, ss));
        btn_h = h;
        btn_m = m;
        repeat (3) @(posedge clk);
        #1;
        btn_h = 1'b0;
        btn_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_hm(int th, int tm);
        while (hh != th) press(1'b1, 1'b0);
        while (mm != tm) press(1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", disp_now(), pack_time(0, 0, 0));
        check("reset_tick", 20'(tick), 20'(0));
        rst = 1'b0;

        run_ticks(10, 1'b0);
        check("ten_ticks", disp_now(), pack_time(0, 0, 10));

        for (int it = 0; it < 4; it++) begin
            enter_set();
            for (int k = $urandom_range(3, 20); k > 0; k--) begin
                sel = $urandom_range(0, 2);
                press(sel != 1, sel != 0);
            end
            leave_set();
            run_ticks($urandom_range(1, 15), 1'b1);
            check("random_run", disp_now(), pack_time(hh, mm, ss));
        end

        enter_set();
        set_hm(23, 59);
        leave_set();
        run_ticks(58, 1'b0);
        check("preload_235958", disp_now(), pack_time(23, 59, 58));
        run_ticks(2, 1'b0);
        check("rollover_000000", disp_now(), 20'h00000);

        enter_set();
        for (int i = 0; i < 24; i++) press(1'b1, 1'b0);
        check("hours_24_presses", disp_now(), 20'h00000);
        for (int i = 0; i < 61; i++) press(1'b0, 1'b1);
        check("minutes_61_presses", disp_now(), 20'h00010);

        hh = (hh + 1) % 24;
        exp_q.push_back(pack_time(hh, mm, ss));
        btn_h = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        btn_h = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held_btn_h", disp_now(), 20'h01010);

        set_hm(9, 59);
        press(1'b1, 1'b1);
        check("same_clk_h_m", disp_now(), 20'h10000);

        leave_set();
        run_ticks(3, 1'b1);
        check("run_buttons_ignored", disp_now(), 20'h10003);

        enter_set();
        set_hm(12, 34);
        @(negedge clk);
        #2;
        rst = 1'b1;
        set_time = 1'b0;
        #1;
        check("async_rst_digits", disp_now(), 20'h00000);
        check("async_rst_tick", 20'(tick), 20'(0));
        check("queue_drained_pre_rst", 20'(exp_q.size()), 20'(0));
        exp_q.delete();
        hh = 0;
        mm = 0;
        ss = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            advance_second();
            exp_q.push_back(pack_time(hh, mm, ss));
        end
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("first_tick_not_early", 20'(sec_led), 20'(0));
        @(posedge clk);
        #1;
        check("first_tick_after_div", 20'(sec_led), 20'(1));
        wait_ticks(2, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_time", disp_now(), 20'h00003);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 20'(exp_q.size()), 20'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_timekeeper.md
CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 Parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick (legal range 2 and up).
REQ-002 Port clk, input, 1, sole system clock; all state changes on rising edge.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port set_time, input, 1, level; high selects SET mode, low selects RUN mode.
REQ-005 Port btn_h, input, 1, raw hour-advance button, asynchronous to clk.
REQ-006 Port btn_m, input, 1, raw minute-advance button, asynchronous to clk.
REQ-007 Port H_1, output, 4, BCD hours tens, range 0-2.
REQ-008 Port H_0, output, 4, BCD hours ones, range 0-9.
REQ-009 Port M_1, output, 4, BCD minutes tens, range 0-5.
REQ-010 Port M_0, output, 4, BCD minutes ones, range 0-9.
REQ-011 Port sec_led, output, 4, BCD seconds ones digit; changes exactly once per tick in RUN.
REQ-012 Port tick, output, 1, one-clk pulse marking each one-second boundary.

Function
REQ-013 Prescaler: counts 0 to TICK_DIV-1 and wraps; tick is high for the single cycle when the count equals TICK_DIV-1.
REQ-014 The prescaler runs in both modes.
REQ-015 State machine: two states, RUN and SET.
- RUN to SET on the first clk with synchronized set_time = 1.
- SET to RUN on the first clk with synchronized set_time = 0.
REQ-016 Internal seconds are held as BCD S_1:S_0; S_0 drives sec_led.
REQ-017 RUN, on tick: seconds increment.
- Wrap 59 to 00 carries into minutes.
- Minutes wrap 59 to 00 carries into hours.
- Hours wrap 23 to 00.
- All carries resolve in the same clk as the tick.
REQ-018 Every ones digit wraps 9 to 0 with a carry into its tens digit; no output ever shows a non-BCD value.
REQ-019 Entering SET clears seconds to 00 in that clk.
- Seconds and time hold while in SET; tick still pulses.
REQ-020 btn_h and btn_m each pass through a two-flop synchronizer, then a rising-edge detector that produces a one-clk pulse.
REQ-021 SET, hour pulse: hours +1 with wrap 23 to 00; minutes unaffected.
REQ-022 SET, minute pulse: minutes +1 with wrap 59 to 00; no carry into hours.
REQ-023 Simultaneous hour and minute pulses in the same clk: both apply.
REQ-024 Button pulses in RUN are ignored.
REQ-025 set_time passes through a two-flop synchronizer; mode-change latency is 2-3 clks from the set_time edge.
REQ-026 Leaving SET: the prescaler is not restarted; the first RUN increment occurs on the next tick.
REQ-027 Outputs are registered; no combinational path from any input to any output.
REQ-028 Digit updates feed the downstream alarm comparator, which is sensitive to digit changes; digits shall change at most once per clk and only on a tick or a SET pulse.

Reset
REQ-029 rst asserted: immediately, without waiting for clk, H_1=H_0=M_1=M_0=0, sec_led=0, S_1=0, tick=0, prescaler=0, state=RUN, synchronizers and edge detectors cleared.
REQ-030 Reset mid-count, or mid-SET, discards all progress; after deassertion the first tick occurs TICK_DIV clks later.
REQ-031 Reset deassertion is assumed synchronous to clk at board level; no internal reset synchronizer.

Structure
REQ-032 Shared package clock_pkg holds:
- constants MAX_H1=2, MAX_H0_AT_H1_2=3, MAX_M1=5, MAX_S1=5, BCD_MAX=9;
- state encodings ST_RUN and ST_SET;
- the shared 4-bit BCD digit width.
REQ-033 One sub-module, bcd_mod_counter: a two-digit BCD counter with parameterized tens and ones limits, plus inc, clear, carry_out and async rst.
- Instantiated for seconds, minutes and hours.
- Hours uses a 23 wrap: the ones limit becomes 3 when the tens digit is 2.
REQ-034 Expected size: 150-300 RTL lines total.

Verification (TICK_DIV=4)
REQ-035 Reset released, 40 clks elapse -> 10 tick pulses 4 clks apart; sec_led 0,1,...,9,0; minutes still 00.
REQ-036 Preload 23:59:58 via SET/RUN, then 2 ticks -> 00:00:00 with all digits updated in the same clk.
REQ-037 SET with 24 btn_h rising edges from 00:00 -> hours 00 after the wrap at 23; minutes unchanged.
- 61 btn_m edges -> minutes 01; hours unchanged.
REQ-038 btn_h held high 20 clks -> exactly one hour increment; btn_m toggling in RUN -> no change.
REQ-039 rst asserted between clk edges while in SET at 12:34 -> outputs 0 before the next clk edge.
- After release the first tick occurs exactly 4 clks later.
REQ-040 Same-clk btn_h and btn_m edges at 09:59 in SET -> 10:00.
